// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment display path: default frame width and
// shift-clock divider (also used by the remap stage and the board top level),
// the serial-shifter state encoding, and a small width helper.
// -----------------------------------------------------------------------------
package seg7_pkg;

    // Two 32-bit remap words, upper word first.
    localparam int SEG7_DATA_W  = 64;
    // System clocks per seg_clk half-period.
    localparam int SEG7_CLK_DIV = 2;

    // Serial shifter state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_LATCH = ST_LATCH,
        S_DONE  = ST_DONE
    } seg7_state_e;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int seg7_cnt_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// -----------------------------------------------------------------------------
// seg7_tick_gen
// Half-period divider for the serial shifter. While enabled it counts
// 0..CLK_DIV-1 and raises tick_o on the last count, i.e. one tick every
// CLK_DIV enabled clocks. The counter wraps to zero on every tick, so a
// frame that ends on a tick leaves it at zero for the next frame.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous reset, active-high
//   clr_i   in   force the counter to zero (frame start)
//   en_i    in   count enable
//   tick_o  out  high during the last cycle of each CLK_DIV-cycle period
// -----------------------------------------------------------------------------
module seg7_tick_gen
    import seg7_pkg::*;
#(
    parameter int CLK_DIV = SEG7_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int              CNT_W    = seg7_cnt_w(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last_s;

    assign at_last_s = (cnt_q == CNT_LAST);
    assign tick_o    = en_i & at_last_s;

    // Next-count logic: clear has priority, then wrap-or-increment when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (at_last_s) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Divider counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg7_serial_shifter.sv
// -----------------------------------------------------------------------------
// seg7_serial_shifter
// Shifts a remapped segment word MSB-first into the board's external
// serial-in/parallel-out shift-register chain, then pulses the storage latch
// so the new pattern appears on the display.
//
// Frame timeline (accept at cycle 0):
//   SHIFT  cycles 1 .. 2*CLK_DIV*DATA_W   (seg_clk low CLK_DIV, high CLK_DIV
//                                          per bit; data changes only as
//                                          seg_clk falls)
//   LATCH  next CLK_DIV cycles            (seg_latch high)
//   DONE   one cycle                      (done high)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   start      in   request one frame (sampled in IDLE only)
//   data       in   DATA_W segment word (sampled on frame accept only)
//   busy       out  high in SHIFT and LATCH
//   done       out  one-cycle pulse after the latch completes
//   seg_clk    out  chain shift clock; chain captures on its rising edge
//   seg_dout   out  chain serial data
//   seg_latch  out  chain storage-register latch, active-high
//   seg_clrn   out  chain clear, active-low (low while in reset)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module seg7_serial_shifter
    import seg7_pkg::*;
#(
    parameter int DATA_W       = SEG7_DATA_W,
    parameter int CLK_DIV      = SEG7_CLK_DIV,
    parameter bit AUTO_REFRESH = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              seg_clk,
    output logic              seg_dout,
    output logic              seg_latch,
    output logic              seg_clrn
);

    localparam int              BIT_W    = seg7_cnt_w(DATA_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    seg7_state_e       state_q,  state_d;
    logic [DATA_W-1:0] shreg_q,  shreg_d;
    logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
    logic              half_q,   half_d;     // drives seg_clk directly
    logic              dout_q,   dout_d;
    logic              latch_q,  latch_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              clrn_q;

    logic              accept_s;
    logic              tick_en_s;
    logic              tick_s;
    logic [DATA_W-1:0] shreg_shl_s;

    // In IDLE a frame starts on request, or unconditionally in auto-refresh mode.
    assign accept_s    = (state_q == S_IDLE) & (start | AUTO_REFRESH);
    assign tick_en_s   = (state_q == S_SHIFT) | (state_q == S_LATCH);
    // Shift via operator so a one-bit frame needs no special-case slicing.
    assign shreg_shl_s = shreg_q << 1;

    seg7_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (accept_s),
        .en_i   (tick_en_s),
        .tick_o (tick_s)
    );

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        half_d   = half_q;
        dout_d   = dout_q;
        latch_d  = latch_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                half_d  = 1'b0;
                dout_d  = 1'b0;
                latch_d = 1'b0;
                busy_d  = 1'b0;
                if (accept_s) begin
                    shreg_d  = data;
                    bitcnt_d = BIT_LAST;
                    dout_d   = data[DATA_W-1];
                    busy_d   = 1'b1;
                    state_d  = S_SHIFT;
                end else begin
                    state_d  = S_IDLE;
                end
            end

            S_SHIFT: begin
                if (tick_s) begin
                    if (!half_q) begin
                        // End of low phase: rising edge, chain samples dout.
                        half_d = 1'b1;
                    end else if (bitcnt_q != '0) begin
                        // End of high phase: falling edge, present next bit.
                        half_d   = 1'b0;
                        shreg_d  = shreg_shl_s;
                        dout_d   = shreg_shl_s[DATA_W-1];
                        bitcnt_d = bitcnt_q - BIT_W'(1);
                    end else begin
                        // Last bit clocked in: park the lines and latch.
                        half_d  = 1'b0;
                        dout_d  = 1'b0;
                        latch_d = 1'b1;
                        state_d = S_LATCH;
                    end
                end else begin
                    state_d = S_SHIFT;
                end
            end

            S_LATCH: begin
                if (tick_s) begin
                    latch_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_LATCH;
                end
            end

            S_DONE: begin
                latch_d = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                half_d  = 1'b0;
                dout_d  = 1'b0;
                latch_d = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            half_q   <= 1'b0;
            dout_q   <= 1'b0;
            latch_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            half_q   <= half_d;
            dout_q   <= dout_d;
            latch_q  <= latch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Chain clear: held low through reset so a half-shifted frame is wiped.
    always_ff @(posedge clk) begin
        if (rst) begin
            clrn_q <= 1'b0;
        end else begin
            clrn_q <= 1'b1;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign seg_clk   = half_q;
    assign seg_dout  = dout_q;
    assign seg_latch = latch_q;
    assign seg_clrn  = clrn_q;

endmodule
